// File: rtl/mips_instr_encoder_loader.sv
// mips_instr_encoder_loader
// Encodes instruction requests into 32-bit decoder-format words and writes them
// sequentially into instruction RAM starting at a latched base address.
// Word format: [31:25] opcode, [24:20] rD, [19:15] rA, [14:0] low ([14:10] = rB).
// Optional feature: define ENCODER_CHECKSUM_EN to build a running XOR checksum of
// every word written; without it the checksum output is tied to zero.
module mips_instr_encoder_loader #(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_ra,
  input  logic [14:0]       in_low,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic [ERR_W-1:0]  err_count,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] index;
  logic              accept;

  // Opcodes the decoder understands.
  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'd0, 7'd1, 7'd2, 7'd5, 7'd7, 7'd8, 7'd10, 7'd12,
      7'd32, 7'd33, 7'd34, 7'd35, 7'd37, 7'd40, 7'd42, 7'd44, 7'd46,
      7'd48, 7'd49, 7'd50, 7'd51, 7'd64, 7'd68, 7'd69,
      7'd96, 7'd97, 7'd98, 7'd101, 7'd127: is_legal = 1'b1;
      default:                             is_legal = 1'b0;
    endcase
  endfunction

  // Opcodes whose low field carries an immediate; the rest keep only rB.
  function automatic logic is_imm(input logic [6:0] op);
    case (op)
      7'd7, 7'd32, 7'd34, 7'd35, 7'd37, 7'd40, 7'd42, 7'd44,
      7'd68, 7'd69, 7'd96, 7'd98, 7'd127: is_imm = 1'b1;
      default:                            is_imm = 1'b0;
    endcase
  endfunction

  // Pack a request into a word; register-form words zero bits [9:0].
  function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] ra, input logic [14:0] low);
    if (is_imm(op)) encode = {op, rd, ra, low};
    else            encode = {op, rd, ra, low[14:10], 10'b0};
  endfunction

  assign in_ready = (state == RUN) && (index < len);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  // Load FSM with registered write port, done pulse and illegal-opcode tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      len         <= '0;
      index       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      mem_we      <= 1'b0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base      <= base_addr;
              len       <= length;
              index     <= '0;
              err_count <= '0;
              if (length == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (accept) begin
              if (is_legal(in_opcode)) begin
                mem_we    <= 1'b1;
                mem_addr  <= base + index;
                mem_wdata <= encode(in_opcode, in_rd, in_ra, in_low);
                index     <= index + ADDR_W'(1);
              end else begin
                err_illegal <= 1'b1;
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
              end
            end else if (index == len) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  // Running XOR of written words; restarts on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (!abort && (state == IDLE) && start) begin
      checksum <= '0;
    end else if (mem_we) begin
      checksum <= checksum ^ mem_wdata;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
